// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 16-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;
  localparam int DATA_W  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Handshake and data bundle between the producers/consumer and the arbiter.
interface mux16_rr_arbiter_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic                      out_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SEL_W-1:0]          select;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;

  // Environment side: producers drive req/data, consumer drives out_ready.
  modport master (
    output req, data_in, out_ready,
    input  out_valid, out_data, select, gnt, ack
  );

  // Arbiter side.
  modport slave (
    input  req, data_in, out_ready,
    output out_valid, out_data, select, gnt, ack
  );

endinterface

// File: rtl/mux16_rr_arbiter_pick.sv
// Rotating priority encoder: first eligible index at or after base, wrapping mod 16.
module rr_pick_16
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   base,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [NUM_REQ-1:0] eligible;

  assign eligible = req & mask;

  // Scan from farthest to nearest so the lowest offset from base wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[base + SEL_W'(k)]) begin
        idx   = base + SEL_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_16.sv
// Existing 16:1 32-bit lane multiplexer.
module mux_16
  import arb_pkg::*;
(
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]         data_out
);

  // Pure lane select, no registering.
  always_comb begin
    data_out = data_in[DATA_W*sel +: DATA_W];
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sequencing the select of a 16:1 lane mux toward one
// valid/ready consumer, with at most MAX_BEATS beats per grant.
module mux16_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BEATS = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  mux16_rr_arbiter_if.slave  bus
);

  arb_state_t         state;
  logic [SEL_W-1:0]   select_q;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   beats;
  logic [NUM_REQ-1:0] gnt_q;

  logic [SEL_W-1:0]   pick_base;
  logic [NUM_REQ-1:0] pick_mask;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic [DATA_W-1:0]  mux_out;

  logic               accept;
  logic               cont;
  logic               leave;
  logic [SEL_W:0]     beats_next;

  // While busy the re-pick starts after the current owner and excludes it;
  // while idle it starts at the round-robin pointer with every lane eligible.
  assign pick_base  = (state == BUSY) ? select_q + 1'b1 : ptr;
  assign pick_mask  = (state == BUSY) ? ~gnt_q : '1;

  assign accept     = (state == BUSY) & bus.out_ready;
  assign beats_next = {1'b0, beats} + 1'b1;
  assign cont       = accept & bus.req[select_q] & (beats_next < (SEL_W+1)'(MAX_BEATS));
  assign leave      = (state == BUSY) & ~cont & (accept | ~bus.req[select_q]);

  rr_pick_16 u_pick (
    .req   (bus.req),
    .mask  (pick_mask),
    .base  (pick_base),
    .idx   (pick_idx),
    .found (pick_found)
  );

  mux_16 u_mux (
    .sel      (select_q),
    .data_in  (bus.data_in),
    .data_out (mux_out)
  );

  assign bus.out_valid = (state == BUSY);
  assign bus.out_data  = (state == BUSY) ? mux_out : '0;
  assign bus.select    = select_q;
  assign bus.gnt       = gnt_q;
  assign bus.ack       = accept ? gnt_q : '0;

  // Grant FSM: owner, round-robin pointer and per-grant beat count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      select_q <= '0;
      ptr      <= '0;
      beats    <= '0;
      gnt_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BUSY;
            select_q <= pick_idx;
            gnt_q    <= onehot(pick_idx);
            beats    <= '0;
          end
        end
        BUSY: begin
          if (cont) begin
            beats <= beats + 1'b1;
          end else if (leave) begin
            ptr   <= select_q + 1'b1;
            beats <= '0;
            if (pick_found) begin
              select_q <= pick_idx;
              gnt_q    <= onehot(pick_idx);
            end else begin
              state <= IDLE;
              gnt_q <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: two instances (MAX_BEATS 4 and 1) share stimulus,
// a rule-level model predicts every cycle, and directed literals pin key points.
module tb_mux16_rr_arbiter;

  localparam int MAXA = 4;
  localparam int MAXB = 1;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [15:0]  req;
  logic [511:0] data_in;
  logic         out_ready;

  int errors = 0;
  int checks = 0;

  int mg[2]     = '{-1, -1};
  int mptr[2]   = '{0, 0};
  int mbeats[2] = '{0, 0};
  int maxb[2]   = '{MAXA, MAXB};

  mux16_rr_arbiter_if ifA ();
  mux16_rr_arbiter_if ifB ();

  assign ifA.req       = req;
  assign ifA.data_in   = data_in;
  assign ifA.out_ready = out_ready;
  assign ifB.req       = req;
  assign ifB.data_in   = data_in;
  assign ifB.out_ready = out_ready;

  mux16_rr_arbiter #(.MAX_BEATS(MAXA)) dutA (.clock(clock), .reset_n(reset_n), .bus(ifA));
  mux16_rr_arbiter #(.MAX_BEATS(MAXB)) dutB (.clock(clock), .reset_n(reset_n), .bus(ifB));

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // First requester at or after base (mod 16), skipping excl; -1 if none.
  function automatic int pickFrom(input logic [15:0] r, input int base, input int excl);
    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = (base + k) % 16;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  // Model: grant owner (-1 idle), pointer and beat count per instance, advanced by the rules.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int m = 0; m < 2; m++) begin
        mg[m]     <= -1;
        mptr[m]   <= 0;
        mbeats[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int g;
        int nb;
        int np;
        g  = mg[m];
        nb = mbeats[m];
        np = mptr[m];
        if (g < 0) begin
          g  = pickFrom(req, np, -1);
          nb = 0;
        end else if (out_ready && req[g] && (mbeats[m] + 1 < maxb[m])) begin
          nb = mbeats[m] + 1;
        end else if (out_ready || !req[g]) begin
          np = (g + 1) % 16;
          nb = 0;
          g  = pickFrom(req, np, g);
        end
        mg[m]     <= g;
        mbeats[m] <= nb;
        mptr[m]   <= np;
      end
    end
  end

  task automatic compareDut(input int m, input logic v, input logic [31:0] d,
                            input logic [3:0] s, input logic [15:0] gn, input logic [15:0] ak);
    int          g;
    logic [15:0] eg;
    logic [31:0] ed;
    g  = mg[m];
    eg = (g >= 0) ? (16'd1 << g) : 16'd0;
    ed = (g >= 0) ? data_in[32*g +: 32] : 32'd0;
    checkOutput($sformatf("model%0d_valid", m), {31'd0, v}, {31'd0, g >= 0});
    checkOutput($sformatf("model%0d_gnt", m), {16'd0, gn}, {16'd0, eg});
    checkOutput($sformatf("model%0d_ack", m), {16'd0, ak}, {16'd0, out_ready ? eg : 16'd0});
    checkOutput($sformatf("model%0d_data", m), d, ed);
    if (g >= 0) checkOutput($sformatf("model%0d_sel", m), {28'd0, s}, g);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    compareDut(0, ifA.out_valid, ifA.out_data, ifA.select, ifA.gnt, ifA.ack);
    compareDut(1, ifB.out_valid, ifB.out_data, ifB.select, ifB.gnt, ifB.ack);
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios with hand-computed expectations (instance A unless noted).
  initial begin
    reset_n = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    for (int i = 0; i < 16; i++) data_in[32*i +: 32] = 32'hCAFE0000 + i;
    data_in[32*5 +: 32] = 32'hDEADBEEF;
    #1;
    checkOutput("rst_valid", {31'd0, ifA.out_valid}, 0);
    checkOutput("rst_gnt", {16'd0, ifA.gnt}, 0);
    checkOutput("rst_sel", {28'd0, ifA.select}, 0);
    checkOutput("rst_data", ifA.out_data, 0);
    step();
    step();
    reset_n = 1'b1;

    // Fairness with every lane requesting.
    applyStimulus(16'hFFFF, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step();
      checkOutput("fair_selB", {28'd0, ifB.select}, i % 16);
      checkOutput("fair_ackB", {16'd0, ifB.ack}, 32'd1 << (i % 16));
      checkOutput("fair_selA", {28'd0, ifA.select}, i / 4);
    end

    // Asynchronous reset mid-stream.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mrst_valid", {31'd0, ifA.out_valid}, 0);
    checkOutput("mrst_gnt", {16'd0, ifA.gnt}, 0);
    checkOutput("mrst_sel", {28'd0, ifA.select}, 0);
    checkOutput("mrst_ack", {16'd0, ifA.ack}, 0);
    step();
    reset_n = 1'b1;
    step();
    checkOutput("mrst_first_selA", {28'd0, ifA.select}, 0);
    checkOutput("mrst_first_selB", {28'd0, ifB.select}, 0);
    checkOutput("mrst_first_valid", {31'd0, ifA.out_valid}, 1);
    applyStimulus(16'h0000, 1'b0);
    step();
    step();
    checkOutput("idle_valid", {31'd0, ifA.out_valid}, 0);

    // Single requester, four beats then one idle cycle.
    applyStimulus(16'h0020, 1'b1);
    step();
    checkOutput("single_sel", {28'd0, ifA.select}, 5);
    checkOutput("single_data", ifA.out_data, 32'hDEADBEEF);
    checkOutput("single_ack", {16'd0, ifA.ack}, 32'h0020);
    step();
    step();
    step();
    checkOutput("single_beat4_ack", {16'd0, ifA.ack}, 32'h0020);
    step();
    checkOutput("single_bubble_valid", {31'd0, ifA.out_valid}, 0);
    checkOutput("single_bubble_data", ifA.out_data, 0);
    checkOutput("single_bubble_gnt", {16'd0, ifA.gnt}, 0);
    step();
    checkOutput("single_regrant_sel", {28'd0, ifA.select}, 5);
    checkOutput("single_regrant_valid", {31'd0, ifA.out_valid}, 1);
    applyStimulus(16'h0000, 1'b0);
    step();
    step();

    // Wrap: park pointer at 15, then 15 and 0 compete.
    applyStimulus(16'h4000, 1'b0);
    step();
    checkOutput("wrap_sel14", {28'd0, ifA.select}, 14);
    applyStimulus(16'h0000, 1'b0);
    step();
    checkOutput("wrap_idle", {31'd0, ifA.out_valid}, 0);
    applyStimulus(16'h8001, 1'b1);
    step();
    checkOutput("wrap_sel15", {28'd0, ifA.select}, 15);
    checkOutput("wrap_sel15B", {28'd0, ifB.select}, 15);
    step();
    checkOutput("wrap_next0B", {28'd0, ifB.select}, 0);
    step();
    step();
    checkOutput("wrap_hold15", {28'd0, ifA.select}, 15);
    step();
    checkOutput("wrap_next0", {28'd0, ifA.select}, 0);
    checkOutput("wrap_ack0", {16'd0, ifA.ack}, 32'h0001);
    applyStimulus(16'h0000, 1'b0);
    step();
    step();

    // Stall while granted to 3.
    applyStimulus(16'h0008, 1'b0);
    step();
    checkOutput("stall_sel", {28'd0, ifA.select}, 3);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("stall_hold_sel", {28'd0, ifA.select}, 3);
      checkOutput("stall_no_ack", {16'd0, ifA.ack}, 0);
      checkOutput("stall_data", ifA.out_data, 32'hCAFE0003);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("stall_release_ack", {16'd0, ifA.ack}, 32'h0008);
    step();
    applyStimulus(16'h0000, 1'b0);
    step();
    step();

    // Abort: 9 drops its request, 2 takes over without an ack to 9.
    applyStimulus(16'h0204, 1'b0);
    step();
    checkOutput("abort_sel9", {28'd0, ifA.select}, 9);
    applyStimulus(16'h0004, 1'b0);
    #1;
    checkOutput("abort_no_ack", {16'd0, ifA.ack}, 0);
    step();
    checkOutput("abort_sel2", {28'd0, ifA.select}, 2);
    applyStimulus(16'h0000, 1'b0);
    step();
    step();

    // Collision: 10 rises in the accept cycle of 9 and beats 2.
    applyStimulus(16'h0204, 1'b0);
    step();
    checkOutput("coll_sel9", {28'd0, ifA.select}, 9);
    applyStimulus(16'h0404, 1'b1);
    #1;
    checkOutput("coll_ack9", {16'd0, ifA.ack}, 32'h0200);
    step();
    checkOutput("coll_sel10", {28'd0, ifA.select}, 10);
    applyStimulus(16'h0000, 1'b0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
